// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm clock datapath
//
// Purpose: state encoding of the alarm controller FSM plus the keypad
// constants shared with the keypad register and the display mux.
// Ports: none (package).
package alarm_pkg;

  localparam int KEY_W = 4;
  localparam logic [KEY_W-1:0] NOKEY = 4'd10;
  localparam int TIMEOUT_S_DEFAULT = 10;
  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    SHOW_ALARM       = 3'd1,
    KEY_STORED       = 3'd2,
    KEY_WAITED       = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_e;

  // The inactivity window only runs while the user is part-way through
  // keying digits.
  function automatic logic is_entry_state(input state_e s);
    return (s == KEY_ENTRY) || (s == KEY_WAITED);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - key-entry inactivity timeout
//
// Purpose: counts one_second pulses while enabled and flags the pulse that
// completes the TIMEOUT_S-second window. Held at zero while disabled.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   enable      in   FSM is in a key-entry state
//   one_second  in   single-cycle pulse once per second
//   timeout     out  high on the cycle of the TIMEOUT_S-th pulse
module timeout_counter #(
  parameter int TIMEOUT_S = 10,
  parameter int CNT_W     = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic one_second,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_S - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!enable) begin
      count_d = '0;
    end else if (one_second && (count_q != LAST)) begin
      // Saturates at LAST: the FSM leaves the counting states on that
      // pulse, so the count never needs to wrap.
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = enable && one_second && (count_q == LAST);

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm clock control FSM
//
// Purpose: decodes keypad, alarm/time buttons and key-entry timeout and
// drives the keypad shift, alarm/clock load strobes and display selects.
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous active-high reset
//   one_second     in   single-cycle pulse once per second
//   key            in   keypad code, 0-9 digit or NOKEY when idle
//   alarm_button   in   level, alarm button held
//   time_button    in   level, time-set button held
//   load_new_a     out  strobe: alarm register captures keyed digits
//   load_new_c     out  strobe: clock counter loads keyed digits
//   reset_count    out  strobe with load_new_c: clear seconds count
//   shift          out  strobe: keypad register shifts in current key
//   show_a         out  display selects alarm time
//   show_new_time  out  display selects keyed digits
module alarm_controller #(
  parameter int                            TIMEOUT_S = alarm_pkg::TIMEOUT_S_DEFAULT,
  parameter int                            CNT_W     = alarm_pkg::CNT_W_DEFAULT,
  parameter logic [alarm_pkg::KEY_W-1:0]   NOKEY     = alarm_pkg::NOKEY
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          one_second,
  input  logic [alarm_pkg::KEY_W-1:0]   key,
  input  logic                          alarm_button,
  input  logic                          time_button,
  output logic                          load_new_a,
  output logic                          load_new_c,
  output logic                          reset_count,
  output logic                          shift,
  output logic                          show_a,
  output logic                          show_new_time
);

  import alarm_pkg::*;

  state_e state_q;
  state_e state_d;
  logic   timeout;
  logic   key_pressed;

  assign key_pressed = (key != NOKEY);

  timeout_counter #(
    .TIMEOUT_S (TIMEOUT_S),
    .CNT_W     (CNT_W)
  ) u_timeout_counter (
    .clock      (clock),
    .reset      (reset),
    .enable     (is_entry_state(state_q)),
    .one_second (one_second),
    .timeout    (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button) begin
          state_d = SHOW_ALARM;
        end else if (key_pressed) begin
          state_d = KEY_STORED;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) begin
          state_d = SHOW_TIME;
        end
      end
      KEY_STORED: begin
        state_d = KEY_WAITED;
      end
      KEY_WAITED: begin
        // Wait for key release so a held key is shifted in only once.
        if (!key_pressed) begin
          state_d = KEY_ENTRY;
        end else if (timeout) begin
          state_d = SHOW_TIME;
        end
      end
      KEY_ENTRY: begin
        if (alarm_button) begin
          state_d = SET_ALARM_TIME;
        end else if (time_button) begin
          state_d = SET_CURRENT_TIME;
        end else if (key_pressed) begin
          state_d = KEY_STORED;
        end else if (timeout) begin
          state_d = SHOW_TIME;
        end
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode: outputs depend on state only, so reset clears them at
  // once and no input reaches an output combinationally.
  always_comb begin
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    reset_count   = 1'b0;
    shift         = 1'b0;
    show_a        = 1'b0;
    show_new_time = 1'b0;
    case (state_q)
      SHOW_ALARM: show_a = 1'b1;
      KEY_STORED: shift  = 1'b1;
      KEY_WAITED: show_new_time = 1'b1;
      KEY_ENTRY:  show_new_time = 1'b1;
      SET_ALARM_TIME: begin
        load_new_a    = 1'b1;
        show_new_time = 1'b1;
      end
      SET_CURRENT_TIME: begin
        load_new_c    = 1'b1;
        reset_count   = 1'b1;
        show_new_time = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;

  localparam logic [3:0] NK = 4'd10;

  // Output vector: {load_new_a, load_new_c, reset_count, shift, show_a, show_new_time}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_SHIFT = 6'b000100;
  localparam logic [5:0] O_SNT   = 6'b000001;
  localparam logic [5:0] O_SA    = 6'b000010;
  localparam logic [5:0] O_LA    = 6'b100001;
  localparam logic [5:0] O_LC    = 6'b011001;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       load_new_a, load_new_c, reset_count, shift, show_a, show_new_time;
  logic [5:0] outs;

  int n_checks = 0;
  int n_fail   = 0;
  int shift_cnt = 0;

  alarm_controller dut (
    .clock         (clock),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .reset_count   (reset_count),
    .shift         (shift),
    .show_a        (show_a),
    .show_new_time (show_new_time)
  );

  assign outs = {load_new_a, load_new_c, reset_count, shift, show_a, show_new_time};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input logic [3:0] k, input logic ab, input logic tbtn, input logic os,
                      input logic [5:0] exp, input string tag);
    key = k;
    alarm_button = ab;
    time_button = tbtn;
    one_second = os;
    @(posedge clock);
    #1;
    check(tag, {26'd0, outs}, {26'd0, exp});
    if (outs[2]) shift_cnt++;
  endtask

  // Key one digit from SHOW_TIME or KEY_ENTRY; ends in KEY_ENTRY.
  task automatic enter_digit(input logic [3:0] d, input string tag);
    step(d,  1'b0, 1'b0, 1'b0, O_SHIFT, {tag, "_stored"});
    step(NK, 1'b0, 1'b0, 1'b0, O_SNT,   {tag, "_waited"});
    step(NK, 1'b0, 1'b0, 1'b0, O_SNT,   {tag, "_entry"});
  endtask

  initial begin
    reset = 1'b1;
    key = NK;
    alarm_button = 1'b0;
    time_button = 1'b0;
    one_second = 1'b0;
    #1;
    check("reset_outs", {26'd0, outs}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "idle_after_reset");

    // Reset mid-operation while in KEY_WAITED
    step(4'd5, 1'b0, 1'b0, 1'b0, O_SHIFT, "rst_key_stored");
    step(4'd5, 1'b0, 1'b0, 1'b0, O_SNT,   "rst_key_waited");
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_outs", {26'd0, outs}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "rst_post_0");
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "rst_post_1");
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "rst_post_2");

    // Single digit held 4 cycles
    shift_cnt = 0;
    step(4'd3, 1'b0, 1'b0, 1'b0, O_SHIFT, "hold_stored");
    step(4'd3, 1'b0, 1'b0, 1'b0, O_SNT,   "hold_waited_0");
    step(4'd3, 1'b0, 1'b0, 1'b0, O_SNT,   "hold_waited_1");
    step(4'd3, 1'b0, 1'b0, 1'b0, O_SNT,   "hold_waited_2");
    step(NK,   1'b0, 1'b0, 1'b0, O_SNT,   "hold_entry");
    step(NK,   1'b0, 1'b0, 1'b0, O_SNT,   "hold_entry_stay");
    check("hold_shift_count", shift_cnt, 1);
    step(NK,   1'b0, 1'b1, 1'b0, O_LC,    "hold_time_load");
    step(NK,   1'b0, 1'b0, 1'b0, O_IDLE,  "hold_back_idle");

    // Alarm load with four digits, button held 3 cycles
    shift_cnt = 0;
    enter_digit(4'd0, "al_d0");
    enter_digit(4'd7, "al_d1");
    enter_digit(4'd3, "al_d2");
    enter_digit(4'd0, "al_d3");
    check("al_shift_count", shift_cnt, 4);
    step(NK, 1'b1, 1'b0, 1'b0, O_LA,   "al_load");
    step(NK, 1'b1, 1'b0, 1'b0, O_IDLE, "al_show_time");
    step(NK, 1'b1, 1'b0, 1'b0, O_SA,   "al_show_alarm");
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "al_release");

    // Both buttons together: alarm wins
    enter_digit(4'd4, "both_d");
    step(NK, 1'b1, 1'b1, 1'b0, O_LA,   "both_load_a");
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "both_idle");

    // Time button only
    enter_digit(4'd8, "tm_d");
    step(NK, 1'b0, 1'b1, 1'b0, O_LC,   "tm_load_c");
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "tm_idle");

    // Timeout: 9 pulses keep KEY_ENTRY, a new digit restarts the window
    enter_digit(4'd1, "to_d0");
    for (int i = 0; i < 9; i++) step(NK, 1'b0, 1'b0, 1'b1, O_SNT, "to_pulse_a");
    step(NK, 1'b0, 1'b0, 1'b0, O_SNT, "to_still_entry");
    enter_digit(4'd2, "to_d1");
    for (int i = 0; i < 9; i++) step(NK, 1'b0, 1'b0, 1'b1, O_SNT, "to_pulse_b");
    step(NK, 1'b0, 1'b0, 1'b1, O_IDLE, "to_expire");
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "to_idle");

    // Show alarm from SHOW_TIME
    shift_cnt = 0;
    for (int i = 0; i < 5; i++) step(NK, 1'b1, 1'b0, 1'b0, O_SA, "sa_held");
    step(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "sa_release");
    check("sa_no_shift", shift_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Control FSM for the alarm clock. It sits directly upstream of the alarm time register and drives its `load_new_a` strobe.
- It also drives the keypad shift register (`shift`), the clock counter load (`load_new_c` / `reset_count`) and the display mux selects (`show_a`, `show_new_time`).
- It decodes keypad activity, the alarm and time buttons, and a key-entry timeout based on `one_second` pulses.

Parameters:
- TIMEOUT_S, 10, number of `one_second` pulses of inactivity in key-entry states before returning to SHOW_TIME.
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_S.
- NOKEY, 4'd10, key code meaning "no key pressed".

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- one_second  input  1  single-cycle pulse, once per second.
- key  input  4  keypad code; 0-9 = digit held, NOKEY = idle; stable while pressed.
- alarm_button  input  1  level, high while the alarm button is held.
- time_button  input  1  level, high while the time-set button is held.
- load_new_a  output  1  one-cycle strobe; alarm register captures the keyed digits.
- load_new_c  output  1  one-cycle strobe; clock counter loads the keyed digits.
- reset_count  output  1  one-cycle strobe, coincident with load_new_c; clears the seconds count.
- shift  output  1  one-cycle strobe; keypad register shifts in the current key.
- show_a  output  1  display selects alarm time.
- show_new_time  output  1  display selects keyed digits.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-high on port `reset`.
- Reset effects: state forced to SHOW_TIME and timeout counter to 0 immediately, independent of `clock`. All outputs go to 0.
- Reset mid-operation: any pending strobe is cancelled. No load occurs after reset deasserts.
- Output style: outputs are pure Moore decode of state, with no combinational path from inputs to outputs.
- States and transitions (evaluated at each rising edge; priority is listed top-down):
  - SHOW_TIME: all outputs 0. alarm_button=1 → SHOW_ALARM. Else key≠NOKEY → KEY_STORED. Else stay.
  - SHOW_ALARM: show_a=1. alarm_button=0 → SHOW_TIME. Else stay.
  - KEY_STORED: shift=1 for exactly one cycle → KEY_WAITED (unconditional).
  - KEY_WAITED: show_new_time=1. key=NOKEY → KEY_ENTRY. Else timeout → SHOW_TIME. Else stay. A held key never causes a second shift.
  - KEY_ENTRY: show_new_time=1. Checks in order:
    - alarm_button=1 → SET_ALARM_TIME.
    - time_button=1 → SET_CURRENT_TIME.
    - key≠NOKEY → KEY_STORED.
    - timeout → SHOW_TIME.
    - otherwise stay.
  - SET_ALARM_TIME: load_new_a=1 and show_new_time=1 for one cycle → SHOW_TIME.
  - SET_CURRENT_TIME: load_new_c=1, reset_count=1 and show_new_time=1 for one cycle → SHOW_TIME.
- Simultaneous buttons: alarm_button wins over time_button, which wins over key, which wins over timeout.
- Timeout counter:
  - Held at 0 in every state except KEY_ENTRY and KEY_WAITED.
  - In those two states it increments on each clock edge where one_second=1.
  - timeout is true when one_second=1 and count == TIMEOUT_S-1, i.e. the transition fires on the edge sampling the TIMEOUT_S-th pulse.
  - Cleared on passing through KEY_STORED, so every new digit restarts the window.
  - Counter never wraps: it leaves the counting states at TIMEOUT_S-1.
- Latencies:
  - alarm_button sampled high in KEY_ENTRY at edge N → load_new_a high during cycle N..N+1.
  - The alarm register captures at edge N+1. State is SHOW_TIME after edge N+1.
- Button held after a load: the FSM returns to SHOW_TIME. If alarm_button is still high, the next edge enters SHOW_ALARM, showing the newly loaded alarm. This is intended.
- Illegal state encodings (unreachable) → SHOW_TIME on next edge.

Decomposition:
- Package `alarm_pkg`: state enum, NOKEY constant, key width (4), TIMEOUT_S default. Shared with the keypad register and display mux.
- One sub-module: `timeout_counter`.
  - Inputs: clock, reset, enable (state in KEY_ENTRY/KEY_WAITED), one_second.
  - Output: timeout.
  - Parameterised by TIMEOUT_S and CNT_W.
- The FSM itself stays in alarm_controller.

Test Plan:
- Reset mid-operation: key=5 pressed from SHOW_TIME, then reset asserted between edges while in KEY_WAITED → all outputs 0 immediately; SHOW_TIME after release; no load strobes.
- Single digit entry: key=3 for 4 cycles, then NOKEY → shift high exactly 1 cycle; show_new_time high from KEY_WAITED onward; state ends in KEY_ENTRY.
- Alarm load: digits 0,7,3,0 entered, then alarm_button=1 for 3 cycles → exactly 4 shift pulses. load_new_a high exactly 1 cycle, 1 cycle after button sampled. Then show_a=1 until button released.
- Time load with simultaneous buttons: in KEY_ENTRY, alarm_button=1 and time_button=1 on the same edge → load_new_a pulses; load_new_c and reset_count stay 0. Repeat with time_button only → load_new_c=reset_count=1 for one cycle.
- Timeout: enter one digit, then 9 one_second pulses → still KEY_ENTRY; 10th pulse → SHOW_TIME next edge, no load strobes. Entering a digit after 9 pulses restarts the count (10 more pulses needed).
- Show alarm: from SHOW_TIME, alarm_button=1 for 5 cycles → show_a=1 for those cycles; 0 one cycle after release; shift and load outputs never asserted.
